pi_mem_arb: RTL and testbench



---
 rtl/pi_mem_arb_if.sv | 50 +++++
 rtl/pi_mem_arb.sv | 192 +++++++++++++++++++
 tb/tb_pi_mem_arb.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/pi_mem_arb_if.sv
// Bundle of the MD client, PI client and cartridge memory port signals around pi_mem_arb.
// The arbiter takes the slave view; the surrounding system (or a bench) takes the master view.
interface pi_mem_arb_if;
    logic        md_stb;
    logic        md_we;
    logic [22:0] md_addr;
    logic [15:0] md_dwr;
    logic [15:0] md_drd;
    logic        md_ack;

    logic        pi_stb;
    logic        pi_we;
    logic [23:0] pi_addr;
    logic [7:0]  pi_dwr;
    logic [7:0]  pi_drd;
    logic        pi_ack;

    logic        mem_req;
    logic        mem_we;
    logic [22:0] mem_addr;
    logic [1:0]  mem_be;
    logic [15:0] mem_dwr;
    logic [15:0] mem_drd;
    logic        mem_ack;

    logic        err;
    logic        err_clr;

    modport slave (
        input  md_stb, md_we, md_addr, md_dwr,
        output md_drd, md_ack,
        input  pi_stb, pi_we, pi_addr, pi_dwr,
        output pi_drd, pi_ack,
        output mem_req, mem_we, mem_addr, mem_be, mem_dwr,
        input  mem_drd, mem_ack,
        output err,
        input  err_clr
    );

    modport master (
        output md_stb, md_we, md_addr, md_dwr,
        input  md_drd, md_ack,
        output pi_stb, pi_we, pi_addr, pi_dwr,
        input  pi_drd, pi_ack,
        input  mem_req, mem_we, mem_addr, mem_be, mem_dwr,
        output mem_drd, mem_ack,
        input  err,
        output err_clr
    );
endinterface

// File: rtl/pi_mem_arb.sv
// Shares one 16-bit cartridge memory port between the MD cart bus and the MCU PI bus.
// MD has priority, PI is forced through after PI_STARVE MD grants, hung accesses time out.
module pi_mem_arb #(
    parameter int unsigned PI_STARVE = 4,
    parameter int unsigned TOUT      = 255
) (
    input logic         clk,
    input logic         rst_n,
    pi_mem_arb_if.slave bus
);
    localparam logic [3:0] StarveMax = 4'(PI_STARVE);
    localparam logic [7:0] ToutLast  = 8'(TOUT - 1);

    typedef enum logic [1:0] {StIdle, StMdCyc, StPiCyc, StDone} state_e;

    state_e      state_q, state_d;
    logic        md_pend_q, md_pend_d, md_we_q, md_we_d;
    logic [22:0] md_addr_q, md_addr_d;
    logic [15:0] md_dwr_q, md_dwr_d;
    logic        pi_pend_q, pi_pend_d, pi_we_q, pi_we_d;
    logic [23:0] pi_addr_q, pi_addr_d;
    logic [7:0]  pi_dwr_q, pi_dwr_d;
    logic [3:0]  streak_q, streak_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        md_ack_q, md_ack_d, pi_ack_q, pi_ack_d;
    logic [15:0] md_drd_q, md_drd_d;
    logic [7:0]  pi_drd_q, pi_drd_d;
    logic        mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [22:0] mem_addr_q, mem_addr_d;
    logic [1:0]  mem_be_q, mem_be_d;
    logic [15:0] mem_dwr_q, mem_dwr_d;
    logic        err_q, err_d;
    logic        tout_hit;

    always_comb begin
        state_d    = state_q;
        md_pend_d  = md_pend_q;
        md_we_d    = md_we_q;
        md_addr_d  = md_addr_q;
        md_dwr_d   = md_dwr_q;
        pi_pend_d  = pi_pend_q;
        pi_we_d    = pi_we_q;
        pi_addr_d  = pi_addr_q;
        pi_dwr_d   = pi_dwr_q;
        streak_d   = streak_q;
        cnt_d      = cnt_q;
        md_ack_d   = 1'b0;
        pi_ack_d   = 1'b0;
        md_drd_d   = md_drd_q;
        pi_drd_d   = pi_drd_q;
        mem_req_d  = mem_req_q;
        mem_we_d   = mem_we_q;
        mem_addr_d = mem_addr_q;
        mem_be_d   = mem_be_q;
        mem_dwr_d  = mem_dwr_q;
        tout_hit   = 1'b0;

        if (bus.md_stb && !md_pend_q) begin
            md_pend_d = 1'b1;
            md_we_d   = bus.md_we;
            md_addr_d = bus.md_addr;
            md_dwr_d  = bus.md_dwr;
        end
        if (bus.pi_stb && !pi_pend_q) begin
            pi_pend_d = 1'b1;
            pi_we_d   = bus.pi_we;
            pi_addr_d = bus.pi_addr;
            pi_dwr_d  = bus.pi_dwr;
        end

        unique case (state_q)
            StIdle: begin
                if (pi_pend_q && (!md_pend_q || streak_q == StarveMax)) begin
                    state_d    = StPiCyc;
                    mem_req_d  = 1'b1;
                    mem_we_d   = pi_we_q;
                    mem_addr_d = pi_addr_q[23:1];
                    // Big-endian lanes: even byte address lives in the high half.
                    mem_be_d   = !pi_we_q ? 2'b11 : (pi_addr_q[0] ? 2'b01 : 2'b10);
                    mem_dwr_d  = pi_addr_q[0] ? {8'h00, pi_dwr_q} : {pi_dwr_q, 8'h00};
                    streak_d   = '0;
                    cnt_d      = '0;
                end else if (md_pend_q) begin
                    state_d    = StMdCyc;
                    mem_req_d  = 1'b1;
                    mem_we_d   = md_we_q;
                    mem_addr_d = md_addr_q;
                    mem_be_d   = 2'b11;
                    mem_dwr_d  = md_dwr_q;
                    cnt_d      = '0;
                    if (!pi_pend_q) begin
                        streak_d = '0;
                    end else if (streak_q != StarveMax) begin
                        streak_d = streak_q + 4'd1;
                    end
                end
            end
            StMdCyc, StPiCyc: begin
                if (bus.mem_ack || cnt_q == ToutLast) begin
                    tout_hit  = !bus.mem_ack;
                    mem_req_d = 1'b0;
                    state_d   = StDone;
                    if (state_q == StMdCyc) begin
                        md_ack_d  = 1'b1;
                        md_pend_d = 1'b0;
                        md_drd_d  = tout_hit ? 16'hFFFF : bus.mem_drd;
                    end else begin
                        pi_ack_d  = 1'b1;
                        pi_pend_d = 1'b0;
                        if (tout_hit) begin
                            pi_drd_d = 8'hFF;
                        end else begin
                            pi_drd_d = pi_addr_q[0] ? bus.mem_drd[7:0] : bus.mem_drd[15:8];
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // A timeout coinciding with err_clr keeps the flag set.
        if (tout_hit) begin
            err_d = 1'b1;
        end else if (bus.err_clr) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            md_pend_q  <= 1'b0;
            md_we_q    <= 1'b0;
            md_addr_q  <= '0;
            md_dwr_q   <= '0;
            pi_pend_q  <= 1'b0;
            pi_we_q    <= 1'b0;
            pi_addr_q  <= '0;
            pi_dwr_q   <= '0;
            streak_q   <= '0;
            cnt_q      <= '0;
            md_ack_q   <= 1'b0;
            pi_ack_q   <= 1'b0;
            md_drd_q   <= '0;
            pi_drd_q   <= '0;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_be_q   <= '0;
            mem_dwr_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            md_pend_q  <= md_pend_d;
            md_we_q    <= md_we_d;
            md_addr_q  <= md_addr_d;
            md_dwr_q   <= md_dwr_d;
            pi_pend_q  <= pi_pend_d;
            pi_we_q    <= pi_we_d;
            pi_addr_q  <= pi_addr_d;
            pi_dwr_q   <= pi_dwr_d;
            streak_q   <= streak_d;
            cnt_q      <= cnt_d;
            md_ack_q   <= md_ack_d;
            pi_ack_q   <= pi_ack_d;
            md_drd_q   <= md_drd_d;
            pi_drd_q   <= pi_drd_d;
            mem_req_q  <= mem_req_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_be_q   <= mem_be_d;
            mem_dwr_q  <= mem_dwr_d;
            err_q      <= err_d;
        end
    end

    assign bus.md_ack   = md_ack_q;
    assign bus.md_drd   = md_drd_q;
    assign bus.pi_ack   = pi_ack_q;
    assign bus.pi_drd   = pi_drd_q;
    assign bus.mem_req  = mem_req_q;
    assign bus.mem_we   = mem_we_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_be   = mem_be_q;
    assign bus.mem_dwr  = mem_dwr_q;
    assign bus.err      = err_q;
endmodule

// File: tb/tb_pi_mem_arb.sv
// Randomized bench for pi_mem_arb: a transaction-level model predicts grants, memory
// port contents, client acks/data and the sticky error flag, checked every cycle.
module tb_pi_mem_arb;
    localparam int PiStarve = 4;
    localparam int Tout     = 8;
    localparam int Never    = 1000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    pi_mem_arb_if bus ();

    pi_mem_arb #(
        .PI_STARVE(PiStarve),
        .TOUT     (Tout)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
        end
    endtask

    typedef enum int {MIdle, MCyc, MDone} mphase_e;

    mphase_e     ph;
    bit          md_pend, pi_pend, serve_pi;
    logic        md_we_m, pi_we_m;
    logic [22:0] md_addr_m;
    logic [15:0] md_dwr_m;
    logic [23:0] pi_addr_m;
    logic [7:0]  pi_dwr_m;
    int          streak, cyc_n, lat;
    bit          exp_md_ack, exp_pi_ack, exp_md_rd, exp_pi_rd, err_m;
    logic [15:0] exp_md_drd;
    logic [7:0]  exp_pi_drd;

    task automatic model_reset();
        ph         = MIdle;
        md_pend    = 1'b0;
        pi_pend    = 1'b0;
        serve_pi   = 1'b0;
        streak     = 0;
        cyc_n      = 0;
        lat        = 0;
        exp_md_ack = 1'b0;
        exp_pi_ack = 1'b0;
        err_m      = 1'b0;
    endtask

    task automatic drive_idle();
        bus.md_stb  = 1'b0;
        bus.md_we   = 1'b0;
        bus.md_addr = '0;
        bus.md_dwr  = '0;
        bus.pi_stb  = 1'b0;
        bus.pi_we   = 1'b0;
        bus.pi_addr = '0;
        bus.pi_dwr  = '0;
        bus.mem_drd = '0;
        bus.mem_ack = 1'b0;
        bus.err_clr = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_ctrl"}, 32'({bus.mem_req, bus.mem_we, bus.md_ack, bus.pi_ack, bus.err,
                                      bus.mem_be}), 32'd0);
        check_eq({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'd0);
        check_eq({tag, "_mem_dwr"}, 32'(bus.mem_dwr), 32'd0);
        check_eq({tag, "_md_drd"}, 32'(bus.md_drd), 32'd0);
        check_eq({tag, "_pi_drd"}, 32'(bus.pi_drd), 32'd0);
    endtask

    // One clock: check the cycle just started, then drive the inputs for the next edge.
    task automatic step(input int md_pct, input int pi_pct, input int never_pct,
                        input int clr_pct);
        bit          tout;
        logic [15:0] rd;
        mphase_e     nx;
        tout = 1'b0;
        @(negedge clk);
        nx = ph;

        check_eq("md_ack", 32'(bus.md_ack), 32'(exp_md_ack));
        if (exp_md_ack && exp_md_rd) check_eq("md_drd", 32'(bus.md_drd), 32'(exp_md_drd));
        check_eq("pi_ack", 32'(bus.pi_ack), 32'(exp_pi_ack));
        if (exp_pi_ack && exp_pi_rd) check_eq("pi_drd", 32'(bus.pi_drd), 32'(exp_pi_drd));
        check_eq("err", 32'(bus.err), 32'(err_m));
        if (exp_md_ack) md_pend = 1'b0;
        if (exp_pi_ack) pi_pend = 1'b0;
        exp_md_ack = 1'b0;
        exp_pi_ack = 1'b0;

        check_eq("mem_req", 32'(bus.mem_req), 32'(ph == MCyc));
        if (ph == MCyc && cyc_n == 0) begin
            if (serve_pi) begin
                check_eq("pi_mem_addr", 32'(bus.mem_addr), 32'(pi_addr_m >> 1));
                check_eq("pi_mem_we", 32'(bus.mem_we), 32'(pi_we_m));
                check_eq("pi_mem_be", 32'(bus.mem_be),
                         !pi_we_m ? 32'd3 : (pi_addr_m[0] ? 32'd1 : 32'd2));
                if (pi_we_m)
                    check_eq("pi_mem_dwr", 32'(bus.mem_dwr),
                             pi_addr_m[0] ? 32'(pi_dwr_m) : 32'(pi_dwr_m) * 256);
            end else begin
                check_eq("md_mem_addr", 32'(bus.mem_addr), 32'(md_addr_m));
                check_eq("md_mem_we", 32'(bus.mem_we), 32'(md_we_m));
                check_eq("md_mem_be", 32'(bus.mem_be), 32'd3);
                if (md_we_m) check_eq("md_mem_dwr", 32'(bus.mem_dwr), 32'(md_dwr_m));
            end
        end

        bus.mem_ack = 1'b0;
        bus.mem_drd = 16'($urandom);
        case (ph)
            MIdle: begin
                if (md_pend || pi_pend) begin
                    serve_pi = pi_pend && (!md_pend || streak == PiStarve);
                    if (serve_pi || !pi_pend) streak = 0;
                    else if (streak < PiStarve) streak = streak + 1;
                    cyc_n = 0;
                    if (int'($urandom_range(99)) < never_pct) lat = Never;
                    else if ($urandom_range(3) == 0) lat = Tout - 1;
                    else lat = int'($urandom_range(2));
                    nx = MCyc;
                end
            end
            MCyc: begin
                if (cyc_n == lat || cyc_n == Tout - 1) begin
                    tout = (cyc_n != lat);
                    if (!tout) bus.mem_ack = 1'b1;
                    rd = tout ? 16'hFFFF : bus.mem_drd;
                    if (serve_pi) begin
                        exp_pi_ack = 1'b1;
                        exp_pi_rd  = !pi_we_m;
                        exp_pi_drd = 8'((rd >> (pi_addr_m[0] ? 0 : 8)) & 16'h00FF);
                    end else begin
                        exp_md_ack = 1'b1;
                        exp_md_rd  = !md_we_m;
                        exp_md_drd = rd;
                    end
                    nx = MDone;
                end
                cyc_n++;
            end
            default: nx = MIdle;
        endcase
        // Stray acks while no access is running must be ignored.
        if (ph != MCyc) bus.mem_ack = ($urandom_range(4) == 0);

        bus.err_clr = (int'($urandom_range(99)) < clr_pct);
        if (tout) err_m = 1'b1;
        else if (bus.err_clr) err_m = 1'b0;

        bus.md_stb  = (int'($urandom_range(99)) < md_pct);
        bus.md_we   = 1'($urandom);
        bus.md_addr = 23'($urandom);
        bus.md_dwr  = 16'($urandom);
        if (bus.md_stb && !md_pend) begin
            md_pend   = 1'b1;
            md_we_m   = bus.md_we;
            md_addr_m = bus.md_addr;
            md_dwr_m  = bus.md_dwr;
        end
        bus.pi_stb  = (int'($urandom_range(99)) < pi_pct);
        bus.pi_we   = 1'($urandom);
        bus.pi_addr = 24'($urandom);
        bus.pi_dwr  = 8'($urandom);
        if (bus.pi_stb && !pi_pend) begin
            pi_pend   = 1'b1;
            pi_we_m   = bus.pi_we;
            pi_addr_m = bus.pi_addr;
            pi_dwr_m  = bus.pi_dwr;
        end
        ph = nx;
    endtask

    initial begin
        int  guard;
        bit  reached;
        drive_idle();
        model_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        repeat (400) step(30, 30, 5, 10);
        repeat (300) step(100, 100, 0, 5);
        repeat (300) step(40, 40, 40, 30);

        // Park an MD access on a memory that never answers, then reset in the middle of it.
        guard   = 0;
        reached = 1'b0;
        while (!reached && guard < 300) begin
            step(100, 0, 100, 0);
            reached = (ph == MCyc) && (cyc_n >= 1) && !serve_pi;
            guard++;
        end
        check_eq("reach_md_cyc", 32'(reached), 32'd1);
        rst_n = 1'b0;
        drive_idle();
        @(negedge clk);
        check_all_zero("mid_reset");
        rst_n = 1'b1;
        model_reset();

        repeat (200) step(30, 30, 5, 10);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
